// File: rtl/multi_prescaler.sv
// Multi-channel runtime-programmable clock divider; ratio updates land on period boundaries.
// Define PRESCALER_STEP_EN to add a push-button single-period step input for channel 0.
module multi_prescaler #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned DEFAULT_RATIO = 2,
    localparam int unsigned SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                quick_clock,
    input  logic                n_reset,
`ifdef PRESCALER_STEP_EN
    input  logic                step,
`endif
    input  logic [CHANNELS-1:0] enable,
    input  logic                ratio_wr,
    input  logic [SEL_W-1:0]    ratio_sel,
    input  logic [WIDTH-1:0]    ratio_data,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] slow_clock,
    output logic [CHANNELS-1:0] tick
);

    logic [WIDTH-1:0]    wr_ratio;
    logic [CHANNELS-1:0] run;
    logic [CHANNELS-1:0] wrap;

    // Ratios below 2 cannot produce both a low and a high phase.
    assign wr_ratio = (ratio_data < WIDTH'(2)) ? WIDTH'(2) : ratio_data;

`ifdef PRESCALER_STEP_EN
    logic [2:0] step_sync_q, step_sync_d;
    logic       step_active_q, step_active_d;
    logic       step_edge;

    always_comb begin
        step_sync_d   = {step_sync_q[1:0], step};
        step_edge     = step_sync_q[1] & ~step_sync_q[2];
        step_active_d = step_active_q;
        if (enable[0]) begin
            step_active_d = 1'b0;
        end else if (step_active_q) begin
            if (wrap[0]) begin
                step_active_d = 1'b0;
            end
        end else if (step_edge) begin
            step_active_d = 1'b1;
        end
    end

    always_ff @(posedge quick_clock or negedge n_reset) begin
        if (!n_reset) begin
            step_sync_q   <= 3'b000;
            step_active_q <= 1'b0;
        end else begin
            step_sync_q   <= step_sync_d;
            step_active_q <= step_active_d;
        end
    end

    assign run = enable | CHANNELS'(step_active_q);
`else
    assign run = enable;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] ratio_q, ratio_d;
        logic [WIDTH-1:0] pend_ratio_q, pend_ratio_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             pending_q, pending_d;
        logic             slow_q, slow_d;
        logic             tick_q, tick_d;
        logic             wr_hit;

        // Out-of-range selects never match any channel index.
        assign wr_hit  = ratio_wr && (32'(ratio_sel) == c);
        assign wrap[c] = run[c] && (cnt_q == ratio_q - WIDTH'(1));

        always_comb begin
            ratio_d      = ratio_q;
            pend_ratio_d = pend_ratio_q;
            cnt_d        = cnt_q;
            pending_d    = pending_q;
            slow_d       = slow_q;
            tick_d       = 1'b0;
            if (run[c]) begin
                if (wrap[c]) begin
                    cnt_d = '0;
                    if (pending_q) begin
                        ratio_d   = pend_ratio_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                slow_d = (cnt_d >= (ratio_d >> 1));
                tick_d = (cnt_d == (ratio_d >> 1));
            end else if (pending_q) begin
                ratio_d   = pend_ratio_q;
                cnt_d     = '0;
                slow_d    = 1'b0;
                pending_d = 1'b0;
            end
            // A write coinciding with an apply becomes the next pending value.
            if (wr_hit) begin
                pend_ratio_d = wr_ratio;
                pending_d    = 1'b1;
            end
        end

        always_ff @(posedge quick_clock or negedge n_reset) begin
            if (!n_reset) begin
                ratio_q      <= WIDTH'(DEFAULT_RATIO);
                pend_ratio_q <= WIDTH'(DEFAULT_RATIO);
                cnt_q        <= '0;
                pending_q    <= 1'b0;
                slow_q       <= 1'b0;
                tick_q       <= 1'b0;
            end else begin
                ratio_q      <= ratio_d;
                pend_ratio_q <= pend_ratio_d;
                cnt_q        <= cnt_d;
                pending_q    <= pending_d;
                slow_q       <= slow_d;
                tick_q       <= tick_d;
            end
        end

        assign pending[c]    = pending_q;
        assign slow_clock[c] = slow_q;
        assign tick[c]       = tick_q;

        a_tick_high: assert property (@(posedge quick_clock) disable iff (!n_reset)
            tick_q |-> slow_q);
        a_cnt_range: assert property (@(posedge quick_clock) disable iff (!n_reset)
            cnt_q < ratio_q);
        a_ratio_min: assert property (@(posedge quick_clock) disable iff (!n_reset)
            ratio_q >= WIDTH'(2));
    end

endmodule

// File: tb/tb_multi_prescaler.sv
// Self-checking bench for multi_prescaler: vector table, directed corner sequences and a
// randomized run scored against a period/position reference model.
module tb_multi_prescaler;
    localparam int unsigned CH = 3;
    localparam int unsigned W  = 16;

    logic          quick_clock = 1'b0;
    logic          n_reset     = 1'b0;
    logic [CH-1:0] enable      = '0;
    logic          ratio_wr    = 1'b0;
    logic [1:0]    ratio_sel   = '0;
    logic [W-1:0]  ratio_data  = '0;
    logic [CH-1:0] pending, slow_clock, tick;
`ifdef PRESCALER_STEP_EN
    logic          step        = 1'b0;
`endif

    multi_prescaler #(
        .CHANNELS(CH),
        .WIDTH(W),
        .DEFAULT_RATIO(2)
    ) dut (
        .quick_clock(quick_clock),
        .n_reset(n_reset),
`ifdef PRESCALER_STEP_EN
        .step(step),
`endif
        .enable(enable),
        .ratio_wr(ratio_wr),
        .ratio_sel(ratio_sel),
        .ratio_data(ratio_data),
        .pending(pending),
        .slow_clock(slow_clock),
        .tick(tick)
    );

    always #5 quick_clock = ~quick_clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: position within the period, active ratio, pending ratio.
    int unsigned   m_r [CH];
    int unsigned   m_pos [CH];
    int unsigned   m_pr [CH];
    bit            m_pv [CH];
    logic [CH-1:0] m_tick;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_r[c] = 2; m_pos[c] = 0; m_pr[c] = 2; m_pv[c] = 1'b0;
        end
        m_tick = '0;
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            m_tick[c] = 1'b0;
            if (enable[c]) begin
                m_pos[c] = (m_pos[c] + 1) % m_r[c];
                if (m_pos[c] == 0 && m_pv[c]) begin
                    m_r[c] = m_pr[c]; m_pv[c] = 1'b0;
                end
                m_tick[c] = (m_pos[c] == m_r[c] / 2);
            end else if (m_pv[c]) begin
                m_r[c] = m_pr[c]; m_pv[c] = 1'b0; m_pos[c] = 0;
            end
            if (ratio_wr && int'(ratio_sel) == c) begin
                m_pr[c] = (ratio_data < 16'd2) ? 32'd2 : 32'(ratio_data);
                m_pv[c] = 1'b1;
            end
        end
    endtask

    function automatic logic [CH-1:0] m_slow();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = (m_pos[c] >= m_r[c] / 2);
        return v;
    endfunction

    function automatic logic [CH-1:0] m_pend();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_pv[c];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle();
        model_step();
        @(posedge quick_clock); #1;
        check("model_slow", 32'(slow_clock), 32'(m_slow()));
        check("model_tick", 32'(tick), 32'(m_tick));
        check("model_pend", 32'(pending), 32'(m_pend()));
    endtask

    task automatic do_reset();
        enable = '0; ratio_wr = 1'b0; ratio_sel = '0; ratio_data = '0;
        n_reset = 1'b0;
        #2;
        check("rst_slow", 32'(slow_clock), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        @(posedge quick_clock); #1;
        @(posedge quick_clock); #1;
        n_reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [2:0]  en;
        logic        wr;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [2:0]  slow;
        logic [2:0]  tck;
        logic [2:0]  pend;
    } vec_t;

    vec_t vecs [15];

    logic [7:0] sa_slow, sa_tick, sa_pend;

    initial begin
        vecs[0]  = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b011, 3'b011, 3'b000};
        vecs[1]  = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[2]  = '{3'b011, 1'b1, 2'd1, 16'd5, 3'b011, 3'b011, 3'b010};
        vecs[3]  = '{3'b001, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[4]  = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b001, 3'b001, 3'b000};
        vecs[5]  = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b010, 3'b010, 3'b000};
        vecs[6]  = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b011, 3'b001, 3'b000};
        vecs[7]  = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
        vecs[8]  = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b001, 3'b001, 3'b000};
        vecs[9]  = '{3'b011, 1'b1, 2'd3, 16'd7, 3'b000, 3'b000, 3'b000};
        vecs[10] = '{3'b011, 1'b1, 2'd0, 16'd0, 3'b011, 3'b011, 3'b001};
        vecs[11] = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
        vecs[12] = '{3'b011, 1'b1, 2'd0, 16'd1, 3'b011, 3'b001, 3'b001};
        vecs[13] = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[14] = '{3'b011, 1'b0, 2'd0, 16'd0, 3'b001, 3'b001, 3'b000};

        #1;
        do_reset();

        // Default ratio, ratio 5 on channel 1, clamped writes, out-of-range select.
        for (int i = 0; i < 15; i++) begin
            enable = vecs[i].en; ratio_wr = vecs[i].wr;
            ratio_sel = vecs[i].sel; ratio_data = vecs[i].data;
            cycle();
            check($sformatf("vec%0d_slow", i), 32'(slow_clock), 32'(vecs[i].slow));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tck));
            check($sformatf("vec%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
        end
        ratio_wr = 1'b0;

        // R=4 on channel 0, rewrite to 6 then 3 mid-period: old period completes, then R=3.
        do_reset();
        ratio_wr = 1'b1; ratio_sel = 2'd0; ratio_data = 16'd4;
        cycle();
        check("seqA_pend_set", 32'(pending[0]), 32'd1);
        ratio_wr = 1'b0;
        cycle();
        check("seqA_pend_clr", 32'(pending[0]), 32'd0);
        sa_slow = 8'b10110110;
        sa_tick = 8'b10010010;
        sa_pend = 8'b00000110;
        enable = 3'b001;
        for (int i = 0; i < 8; i++) begin
            ratio_wr = (i == 1) || (i == 2);
            ratio_data = (i == 1) ? 16'd6 : 16'd3;
            cycle();
            check($sformatf("seqA_slow%0d", i), 32'(slow_clock[0]), 32'(sa_slow[i]));
            check($sformatf("seqA_tick%0d", i), 32'(tick[0]), 32'(sa_tick[i]));
            check($sformatf("seqA_pend%0d", i), 32'(pending[0]), 32'(sa_pend[i]));
        end
        ratio_wr = 1'b0;

        // R=8 on channel 1, pause at counter 5, resume, then reset mid-period.
        do_reset();
        ratio_wr = 1'b1; ratio_sel = 2'd1; ratio_data = 16'd8;
        cycle();
        ratio_wr = 1'b0;
        cycle();
        enable = 3'b010;
        for (int i = 0; i < 5; i++) cycle();
        check("seqB_cnt5_slow", 32'(slow_clock[1]), 32'd1);
        enable = 3'b000;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("seqB_hold_slow", 32'(slow_clock[1]), 32'd1);
            check("seqB_hold_tick", 32'(tick[1]), 32'd0);
        end
        enable = 3'b010;
        cycle();
        check("seqB_resume1", 32'(slow_clock[1]), 32'd1);
        cycle();
        check("seqB_resume2", 32'(slow_clock[1]), 32'd1);
        cycle();
        check("seqB_period_end", 32'(slow_clock[1]), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        ratio_wr = 1'b1; ratio_sel = 2'd0; ratio_data = 16'd9;
        cycle();
        ratio_wr = 1'b0;
        check("seqB_pre_rst_pend", 32'(pending[0]), 32'd1);
        check("seqB_pre_rst_slow", 32'(slow_clock[1]), 32'd1);
        do_reset();
        enable = 3'b010;
        cycle();
        check("seqB_r2_slow_hi", 32'(slow_clock[1]), 32'd1);
        check("seqB_r2_tick", 32'(tick[1]), 32'd1);
        cycle();
        check("seqB_r2_slow_lo", 32'(slow_clock[1]), 32'd0);
        check("seqB_pend_lost", 32'(pending), 32'd0);

        // Randomized traffic scored against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) enable[c] = ($urandom_range(0, 9) != 0);
            ratio_wr   = ($urandom_range(0, 7) == 0);
            ratio_sel  = 2'($urandom_range(0, 3));
            ratio_data = 16'($urandom_range(0, 9));
            cycle();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

`ifdef PRESCALER_STEP_EN
        begin
            int ticks, highs;
            do_reset();
            ratio_wr = 1'b1; ratio_sel = 2'd0; ratio_data = 16'd4;
            cycle();
            ratio_wr = 1'b0;
            cycle();
            for (int k = 0; k < 2; k++) begin
                ticks = 0; highs = 0;
                step = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(posedge quick_clock); #1;
                    ticks += int'(tick[0]);
                    highs += int'(slow_clock[0]);
                end
                step = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(posedge quick_clock); #1;
                end
                check("step_ticks", 32'(ticks), 32'd1);
                check("step_highs", 32'(highs), 32'd2);
                check("step_frozen", 32'(slow_clock[0]), 32'd0);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
